nios_sys_nios2_processor_ocimem_responder: RTL
==============================================

// Module: nios_sys_nios2_processor_ocimem_responder
//
// PURPOSE
// System-clock responder for the debug module's OCI memory commands. Consumes the
// take_action/take_no_action pulses and 38-bit jdo word from the debug sysclk
// block, runs the requested Avalon-MM read or write, and returns MonDReg plus
// monitor_ready/monitor_error for the TCK-side capture register.
// Sits between the debug sysclk block and the processor's data master arbiter.
//
// PARAMETERS
// ADDR_W     32   byte-address width of avm_address
// TIMEOUT    255  max cycles avm_waitrequest may stay high before abort (1..65535)
//
// PORTS
// clk                      in   1       system clock
// reset_n                  in   1       asynchronous reset, active-low
// jdo                      in   38      command/data word, stable on command pulse cycle
// take_action_ocimem_a     in   1       pulse: load address/control from jdo
// take_action_ocimem_b     in   1       pulse: write jdo[31:0] at current address
// take_no_action_ocimem_a  in   1       pulse: read at current address
// MonDReg                  out  32      last read data
// monitor_ready            out  1       1 = idle, result valid
// monitor_error            out  1       sticky error flag
// avm_address              out  ADDR_W  word-aligned byte address ([1:0]=0)
// avm_read                 out  1       Avalon read strobe
// avm_write                out  1       Avalon write strobe
// avm_writedata            out  32      write data
// avm_byteenable           out  4       always 4'hF
// avm_readdata             in   32      read data, valid when avm_read && !avm_waitrequest
// avm_waitrequest          in   1       slave stall
//
// BEHAVIOUR
// - Reset (async, reset_n=0): MonDReg=0, monitor_ready=1, monitor_error=0,
//   avm_read=avm_write=0, avm_address=0, avm_writedata=0, addr reg=0, autoinc=0, FSM=IDLE.
// - jdo decode on take_action_ocimem_a: addr <= {jdo[ADDR_W-1:2],2'b00};
//   autoinc <= jdo[35]; jdo[34]=1 -> also start read (same as a read pulse);
//   clears monitor_error. Accepted in any state; if busy it only updates addr/autoinc
//   for the NEXT access (in-flight bus cycle unaffected).
// - FSM states IDLE, RD, WR, DONE.
//   IDLE: read pulse -> RD; write pulse -> WR (avm_writedata <= jdo[31:0]);
//     monitor_ready drops to 0 the cycle after the pulse.
//   RD: avm_read=1, avm_address=addr. On !avm_waitrequest: MonDReg <= avm_readdata -> DONE.
//   WR: avm_write=1. On !avm_waitrequest -> DONE.
//   DONE (1 cycle): strobes 0; monitor_ready=1; if autoinc addr <= addr+4 (wraps mod 2^ADDR_W) -> IDLE.
// - Latency: pulse at cycle N -> strobe high N+1; zero-wait slave -> monitor_ready=1 at N+3.
// - Strobes and address/writedata held constant while avm_waitrequest=1.
// - Timeout: wait counter resets on entering RD/WR; if it reaches TIMEOUT with
//   waitrequest still 1, drop strobe, monitor_error=1, MonDReg unchanged, addr not
//   incremented, -> IDLE with monitor_ready=1.
// - Read/write pulse while not IDLE: ignored, monitor_error=1 (sticky).
// - Simultaneous pulses same cycle: priority ocimem_a (load) > ocimem_b (write) >
//   no_action_ocimem_a (read); lower ones are dropped without error, except the
//   jdo[34] read-on-load path.
// - Reset mid-transaction: strobes drop immediately (async), no completion reported.
//
// TESTING
// 1 Load jdo[31:0]=0x1000, jdo[35]=1; two read pulses, zero-wait slave returning
//   0xA5A5_0001/0xA5A5_0002 -> addresses 0x1000,0x1004; MonDReg matches; ready at N+3.
// 2 Write pulse jdo[31:0]=0xCAFEF00D, waitrequest high 5 cycles -> avm_write held 6
//   cycles, writedata/address stable, byteenable=4'hF, ready after release.
// 3 Waitrequest stuck high, TIMEOUT=8 -> strobe drops after 8 cycles, monitor_error=1,
//   ready=1, address not incremented; next ocimem_a load clears error.
// 4 Read pulse while RD in progress -> ignored, monitor_error=1, first read completes normally.
// 5 autoinc with addr=0xFFFF_FFFC, read -> next address 0x0000_0000.
// 6 reset_n low during WR with waitrequest high -> avm_write=0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/nios_sys_nios2_processor_ocimem_responder.sv
// rtl/nios_sys_nios2_processor_ocimem_responder.sv - system-clock responder for debug OCI memory commands
module nios_sys_nios2_processor_ocimem_responder #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              autoinc;
  logic [15:0]       wait_cnt;

  // Command decode: a load pre-empts write and read pulses in the same cycle.
  logic              load;
  logic              load_rd;
  logic              wr_req;
  logic              rd_req;
  logic [ADDR_W-1:0] load_addr;
  logic              busy_bus;
  logic              timed_out;
  logic              start_rd;
  logic              start_wr;
  logic              unused_jdo;

  assign load      = take_action_ocimem_a;
  assign load_rd   = take_action_ocimem_a & jdo[34];
  assign wr_req    = take_action_ocimem_b & ~take_action_ocimem_a;
  assign rd_req    = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign load_addr = {jdo[ADDR_W-1:2], 2'b00};
  assign busy_bus  = (state == S_RD) || (state == S_WR);
  assign timed_out = busy_bus && avm_waitrequest && (wait_cnt == 16'(TIMEOUT - 1));
  assign start_rd  = (state == S_IDLE) && (state_nxt == S_RD);
  assign start_wr  = (state == S_IDLE) && (state_nxt == S_WR);
  assign unused_jdo = ^{jdo[37:36], jdo[33:32]};

  // Strobes come straight from the state so an async reset drops them at once.
  assign avm_read       = (state == S_RD);
  assign avm_write      = (state == S_WR);
  assign avm_byteenable = 4'hF;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: start accesses from IDLE, finish on accept or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (load_rd)     state_nxt = S_RD;
        else if (wr_req) state_nxt = S_WR;
        else if (rd_req) state_nxt = S_RD;
      end
      S_RD, S_WR: begin
        if (!avm_waitrequest) state_nxt = S_DONE;
        else if (timed_out)   state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address/control, bus cycle registers, result and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr          <= '0;
      autoinc       <= 1'b0;
      wait_cnt      <= '0;
      avm_address   <= '0;
      avm_writedata <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      // A load only steers the next access; the in-flight address is separate.
      if (load) begin
        addr    <= load_addr;
        autoinc <= jdo[35];
      end else if (state == S_DONE && autoinc) begin
        addr <= addr + ADDR_W'(4);
      end

      if (start_rd || start_wr) begin
        avm_address   <= load ? load_addr : addr;
        wait_cnt      <= '0;
        monitor_ready <= 1'b0;
      end else if (busy_bus && avm_waitrequest) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      if (start_wr) avm_writedata <= jdo[31:0];

      if (state == S_RD && !avm_waitrequest) MonDReg <= avm_readdata;

      if (state == S_DONE || timed_out) monitor_ready <= 1'b1;

      // Errors are sticky until the next load; a timeout wins over a clear.
      if (timed_out || (state != S_IDLE && (wr_req || rd_req)))
        monitor_error <= 1'b1;
      else if (load)
        monitor_error <= 1'b0;
    end
  end

endmodule
